// File: rtl/mul_pkg.sv
// Shared types and helpers for the shift-add multiplier.
package mul_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Iteration counter width; kept at least one bit so WIDTH=1 still elaborates.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/mul_sa_datapath.sv
// Shift-add datapath: operand magnitudes, accumulator, iteration counter and
// the sign-corrected product register.
module mul_sa_datapath
   import mul_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter bit EARLY_TERM = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_load,
   input  logic                 i_step,
   input  logic [WIDTH-1:0]     i_a,
   input  logic [WIDTH-1:0]     i_b,
   input  logic                 i_signed_mode,
   output logic                 o_zero_b,
   output logic                 o_last,
   output logic [2*WIDTH-1:0]   o_product
);

   localparam int CW = cnt_width(WIDTH);

   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH-1:0]   w_mb_shift;
   logic [2*WIDTH-1:0] w_acc_nxt;
   logic [2*WIDTH-1:0] r_ma;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_product;
   logic [WIDTH-1:0]   r_mb;
   logic [CW-1:0]      r_cnt;
   logic               r_sign;

   function automatic logic [2*WIDTH-1:0] apply_sign(input logic s,
                                                     input logic [2*WIDTH-1:0] v);
      return s ? -v : v;
   endfunction

   // Negating -2^(W-1) yields the same bit pattern, which read unsigned is 2^(W-1).
   always_comb begin
      w_abs_a    = (i_signed_mode && i_a[WIDTH-1]) ? -i_a : i_a;
      w_abs_b    = (i_signed_mode && i_b[WIDTH-1]) ? -i_b : i_b;
      w_mb_shift = r_mb >> 1;
      w_acc_nxt  = r_acc + (r_mb[0] ? r_ma : '0);
      o_zero_b   = (w_abs_b == '0);
      o_last     = (r_cnt == CW'(WIDTH-1)) || (EARLY_TERM && (w_mb_shift == '0));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ma      <= '0;
         r_mb      <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_sign    <= 1'b0;
         r_product <= '0;
      end else if (i_load) begin
         r_ma   <= {{WIDTH{1'b0}}, w_abs_a};
         r_mb   <= w_abs_b;
         r_acc  <= '0;
         r_cnt  <= '0;
         r_sign <= i_signed_mode & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
         if (EARLY_TERM && o_zero_b)
            r_product <= '0;
      end else if (i_step) begin
         r_acc <= w_acc_nxt;
         r_ma  <= r_ma << 1;
         r_mb  <= w_mb_shift;
         r_cnt <= r_cnt + 1'b1;
         if (o_last)
            r_product <= apply_sign(r_sign, w_acc_nxt);
      end
   end

   assign o_product = r_product;

endmodule

// File: rtl/mul_shift_add_seq.sv
// Sequential radix-2 shift-add multiplier with valid/ready handshakes,
// signed/unsigned mode and optional early termination.
module mul_shift_add_seq
   import mul_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter bit EARLY_TERM = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 signed_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   state_t r_state;
   state_t w_state_nxt;
   logic   w_accept;
   logic   w_zero_b;
   logic   w_last;
   logic   w_skip_run;

   assign w_accept   = in_valid && in_ready;
   assign w_skip_run = EARLY_TERM && w_zero_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = w_skip_run ? DONE : RUN;
         RUN:     if (w_last)   w_state_nxt = DONE;
         DONE: begin
            if (out_ready) begin
               if (in_valid) w_state_nxt = w_skip_run ? DONE : RUN;
               else          w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // A finished product can be drained and a new operand set taken on one edge.
   always_comb begin
      in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
      out_valid = (r_state == DONE);
      busy      = (r_state == RUN);
   end

   mul_sa_datapath #(
      .WIDTH      (WIDTH),
      .EARLY_TERM (EARLY_TERM)
   ) u_datapath (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_load        (w_accept),
      .i_step        (busy),
      .i_a           (a),
      .i_b           (b),
      .i_signed_mode (signed_mode),
      .o_zero_b      (w_zero_b),
      .o_last        (w_last),
      .o_product     (product)
   );

endmodule

// File: tb/tb_mul_shift_add_seq.sv
// Randomized and directed bench for mul_shift_add_seq against an arithmetic reference.
module tb_mul_shift_add_seq;

   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid, in_ready, out_valid, out_ready, busy;
   logic [W-1:0]   a, b;
   logic           signed_mode;
   logic [2*W-1:0] product;

   logic           in_valid2, in_ready2, out_valid2, out_ready2, busy2;
   logic [2*W-1:0] product2;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mul_shift_add_seq #(.WIDTH(W), .EARLY_TERM(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid),
      .out_ready(out_ready), .product(product), .busy(busy)
   );

   mul_shift_add_seq #(.WIDTH(W), .EARLY_TERM(1'b0)) u_dut_nt (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
      .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid2),
      .out_ready(out_ready2), .product(product2), .busy(busy2)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                               input logic sm);
      longint p;
      if (sm) p = longint'($signed(ta)) * longint'($signed(tb_));
      else    p = longint'(ta) * longint'(tb_);
      return p[2*W-1:0];
   endfunction

   function automatic int ref_n(input logic [W-1:0] tb_, input logic sm, input bit et);
      int bi;
      int n;
      if (!et) return W;
      bi = sm ? int'($signed(tb_)) : int'(tb_);
      if (bi < 0) bi = -bi;
      n = 0;
      while (bi != 0) begin
         n++;
         bi = bi / 2;
      end
      return n;
   endfunction

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tsm,
                         output int lat, output int bcnt, output logic [2*W-1:0] prod);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      a = ta; b = tb_; signed_mode = tsm; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
      lat  = 1;
      bcnt = 0;
      while (!out_valid && lat < 100) begin
         if (busy) bcnt++;
         @(posedge clk);
         #1;
         lat++;
      end
      prod = product;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat, bcnt, n;
      logic [2*W-1:0] prod;
      logic [W-1:0]   ra, rb;
      logic           rsm;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_valid2 = 1'b0; out_ready2 = 1'b1;
      a = '0; b = '0; signed_mode = 1'b0;
      #23;
      chk("rst_product", product, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(16'd17, 16'd5, 1'b0, lat, bcnt, prod);
      chk("u17x5_prod", prod, 32'h0000_0055);
      chk("u17x5_lat", lat, 4);
      chk("u17x5_busy", bcnt, 3);

      run_op(16'hFFFD, 16'd7, 1'b1, lat, bcnt, prod);
      chk("sm3x7_prod", prod, 32'hFFFF_FFEB);
      chk("sm3x7_lat", lat, 4);

      run_op(16'h8000, 16'h8000, 1'b1, lat, bcnt, prod);
      chk("minxmin_prod", prod, 32'h4000_0000);
      chk("minxmin_lat", lat, 17);

      run_op(16'hFFFF, 16'h0000, 1'b0, lat, bcnt, prod);
      chk("bzero_prod", prod, 0);
      chk("bzero_lat", lat, 1);
      chk("bzero_busy", bcnt, 0);

      // Same zero multiplier on the instance without early termination.
      @(negedge clk);
      a = 16'hFFFF; b = 16'h0000; signed_mode = 1'b0; in_valid2 = 1'b1;
      @(posedge clk);
      #1;
      in_valid2 = 1'b0;
      lat = 1;
      while (!out_valid2 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("nt_bzero_prod", product2, 0);
      chk("nt_bzero_lat", lat, 17);

      // Backpressure: hold the result, then drain and accept on one edge.
      out_ready = 1'b0;
      run_op(16'd17, 16'd5, 1'b0, lat, bcnt, prod);
      chk("bp_first_prod", prod, 85);
      @(negedge clk);
      a = 16'd2; b = 16'd3; signed_mode = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_hold_prod", product, 85);
         chk("bp_hold_valid", out_valid, 1);
         chk("bp_hold_in_ready", in_ready, 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      chk("bp_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_hs_valid", out_valid, 0);
      chk("bp_hs_busy", busy, 1);
      chk("bp_hs_prod_held", product, 85);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("bp_2x3_lat", lat, 3);
      chk("bp_2x3_prod", product, 6);

      // Reset in the fifth RUN cycle of a long operation.
      @(negedge clk);
      a = 16'hFFFF; b = 16'hFFFF; signed_mode = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      chk("mid_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_prod", product, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(16'd2, 16'd2, 1'b0, lat, bcnt, prod);
      chk("post_rst_prod", prod, 4);
      chk("post_rst_lat", lat, 3);

      // Random regression with a bias towards short multipliers and extremes.
      for (int k = 0; k < 1000; k++) begin
         ra  = W'($urandom);
         rb  = W'($urandom);
         rsm = 1'($urandom);
         case ($urandom_range(0, 3))
            0: rb = rb >> $urandom_range(0, W-1);
            1: ra = 16'h8000;
            2: rb = ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'h0000;
            default: ;
         endcase
         run_op(ra, rb, rsm, lat, bcnt, prod);
         n = ref_n(rb, rsm, 1'b1);
         chk("rand_prod", prod, ref_prod(ra, rb, rsm));
         chk("rand_lat", lat, n + 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
